// File: rtl/regbank_wb_arbiter_if.sv
// Writeback request bus between the requesters and the register-bank write-port arbiter.
// The master side drives requests and stall; the slave side returns grants and the bank write.
interface regbank_wb_arbiter_if #(
    parameter int N_REQ = 3
);
    logic [N_REQ-1:0]    req_valid;
    logic [4*N_REQ-1:0]  req_addr;
    logic [32*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic                stall;
    logic [15:0]         wr;
    logic [31:0]         data_in;
    logic [1:0]          grant_id;
    logic                wr_active;

    modport master (
        output req_valid, req_addr, req_data, stall,
        input  req_ready, wr, data_in, grant_id, wr_active
    );

    modport slave (
        input  req_valid, req_addr, req_data, stall,
        output req_ready, wr, data_in, grant_id, wr_active
    );
endinterface

// File: rtl/regbank_wb_arbiter.sv
// Round-robin arbiter for the single write port of the 16x32 register bank.
// One grant per cycle; the granted write is decoded and presented to the bank from registers.
module regbank_wb_arbiter #(
    parameter int N_REQ      = 3,
    parameter bit PROTECT_R0 = 1'b0
) (
    input logic                 clk,
    input logic                 rst,
    regbank_wb_arbiter_if.slave bus
);
    localparam int DATA_W = 32;

    logic [1:0]        r_ptr;
    logic [15:0]       r_wr_p1;
    logic [DATA_W-1:0] r_data_p1;
    logic [1:0]        r_gid_p1;
    logic              r_act_p1;

    logic [3:0]        w_valid4;
    logic              w_any;
    logic [1:0]        w_idx;
    logic [3:0]        w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic [3:0]        w_ready4;

    // A write to r0 is still a completed transfer when protected; only the strobe is dropped.
    function automatic logic [15:0] f_decode(input logic [3:0] addr);
        if (PROTECT_R0 && (addr == 4'd0)) begin
            return 16'd0;
        end
        return 16'd1 << addr;
    endfunction

    assign w_valid4 = 4'(bus.req_valid);

    // Stage 0: rotating-priority search starting at r_ptr
    always_comb begin : p_arb
        logic [2:0] cand;
        cand  = 3'd0;
        w_any = 1'b0;
        w_idx = 2'd0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, r_ptr} + 3'(k);
            if (cand >= 3'(N_REQ)) begin
                cand = cand - 3'(N_REQ);
            end
            if (!w_any && w_valid4[cand[1:0]]) begin
                w_any = 1'b1;
                w_idx = cand[1:0];
            end
        end
        if (rst || bus.stall) begin
            w_any = 1'b0;
        end
    end

    always_comb begin
        w_sel_addr = 4'd0;
        w_sel_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_idx == 2'(k)) begin
                w_sel_addr = bus.req_addr[4*k +: 4];
                w_sel_data = bus.req_data[DATA_W*k +: DATA_W];
            end
        end
    end

    assign w_ready4      = {3'b000, w_any} << w_idx;
    assign bus.req_ready = w_ready4[N_REQ-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 2'd0;
        end else if (w_any) begin
            r_ptr <= (w_idx == 2'(N_REQ - 1)) ? 2'd0 : w_idx + 2'd1;
        end
    end

    // Stage 1: registered bank write; data/grant_id hold across idle cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_p1   <= 16'd0;
            r_data_p1 <= '0;
            r_gid_p1  <= 2'd0;
            r_act_p1  <= 1'b0;
        end else if (w_any) begin
            r_wr_p1   <= f_decode(w_sel_addr);
            r_data_p1 <= w_sel_data;
            r_gid_p1  <= w_idx;
            r_act_p1  <= 1'b1;
        end else begin
            r_wr_p1   <= 16'd0;
            r_act_p1  <= 1'b0;
        end
    end

    assign bus.wr        = r_wr_p1;
    assign bus.data_in   = r_data_p1;
    assign bus.grant_id  = r_gid_p1;
    assign bus.wr_active = r_act_p1;
endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Bench for regbank_wb_arbiter: directed scenarios plus random traffic against a behavioural model.
// Two instances share stimulus, one with r0 protection enabled.
module tb_regbank_wb_arbiter;
    localparam int N = 3;

    logic         clk;
    logic         rst;
    logic [N-1:0] tv_valid;
    logic [3:0]   tv_addr [N];
    logic [31:0]  tv_data [N];
    logic         tv_stall;

    regbank_wb_arbiter_if #(.N_REQ(N)) bus_a ();
    regbank_wb_arbiter_if #(.N_REQ(N)) bus_b ();

    regbank_wb_arbiter #(.N_REQ(N), .PROTECT_R0(1'b0)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    regbank_wb_arbiter #(.N_REQ(N), .PROTECT_R0(1'b1)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    always_comb begin
        bus_a.req_valid = tv_valid;
        bus_b.req_valid = tv_valid;
        bus_a.stall     = tv_stall;
        bus_b.stall     = tv_stall;
        bus_a.req_addr  = '0;
        bus_b.req_addr  = '0;
        bus_a.req_data  = '0;
        bus_b.req_data  = '0;
        for (int k = 0; k < N; k++) begin
            bus_a.req_addr[4*k +: 4]   = tv_addr[k];
            bus_b.req_addr[4*k +: 4]   = tv_addr[k];
            bus_a.req_data[32*k +: 32] = tv_data[k];
            bus_b.req_data[32*k +: 32] = tv_data[k];
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks;
    int          n_pass;
    int          m_ptr;
    logic [15:0] e_wr_a;
    logic [15:0] e_wr_b;
    logic [31:0] e_data;
    logic [1:0]  e_gid;
    logic        e_act;
    logic [31:0] m_bank [16];
    logic [31:0] t_bank [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational grant, advance the model at the edge, check registered outputs.
    task automatic step(output int g);
        logic [N-1:0] exp_rdy;
        #1;
        g = -1;
        if (!rst && !tv_stall) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (g < 0 && tv_valid[i]) g = i;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("ready_a", 32'(bus_a.req_ready), 32'(exp_rdy));
        check("ready_b", 32'(bus_b.req_ready), 32'(exp_rdy));
        @(posedge clk);
        if (rst) begin
            m_ptr  = 0;
            e_wr_a = 16'd0;
            e_wr_b = 16'd0;
            e_data = 32'd0;
            e_gid  = 2'd0;
            e_act  = 1'b0;
        end else if (g >= 0) begin
            e_wr_a = 16'(1) << tv_addr[g];
            e_wr_b = (tv_addr[g] == 4'd0) ? 16'd0 : e_wr_a;
            e_data = tv_data[g];
            e_gid  = 2'(g);
            e_act  = 1'b1;
            m_ptr  = (g + 1) % N;
            m_bank[tv_addr[g]] = tv_data[g];
        end else begin
            e_wr_a = 16'd0;
            e_wr_b = 16'd0;
            e_act  = 1'b0;
        end
        #1;
        check("wr_a",   32'(bus_a.wr),        32'(e_wr_a));
        check("data_a", bus_a.data_in,        e_data);
        check("gid_a",  32'(bus_a.grant_id),  32'(e_gid));
        check("act_a",  32'(bus_a.wr_active), 32'(e_act));
        check("wr_b",   32'(bus_b.wr),        32'(e_wr_b));
        check("data_b", bus_b.data_in,        e_data);
        check("gid_b",  32'(bus_b.grant_id),  32'(e_gid));
        check("act_b",  32'(bus_b.wr_active), 32'(e_act));
        for (int b = 0; b < 16; b++) begin
            if (bus_a.wr[b]) t_bank[b] = bus_a.data_in;
        end
        @(negedge clk);
    endtask

    int          g;
    logic [15:0] exp_wr;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_ptr    = 0;
        e_wr_a   = 16'd0;
        e_wr_b   = 16'd0;
        e_data   = 32'd0;
        e_gid    = 2'd0;
        e_act    = 1'b0;
        for (int b = 0; b < 16; b++) begin
            m_bank[b] = 32'd0;
            t_bank[b] = 32'd0;
        end
        rst      = 1'b1;
        tv_stall = 1'b0;
        tv_valid = '1;
        for (int k = 0; k < N; k++) begin
            tv_addr[k] = 4'd9;
            tv_data[k] = $urandom;
        end

        // Requests present during reset must not be accepted
        step(g);
        step(g);
        rst      = 1'b0;
        tv_valid = '0;
        step(g);

        // Single request
        tv_valid   = 3'b001;
        tv_addr[0] = 4'd5;
        tv_data[0] = 32'hDEADBEEF;
        step(g);
        check("single_wr",   32'(bus_a.wr), 32'h0000_0020);
        check("single_data", bus_a.data_in, 32'hDEADBEEF);
        check("single_gid",  32'(bus_a.grant_id), 32'd0);
        tv_valid = '0;
        step(g);
        check("single_wr_end", 32'(bus_a.wr), 32'd0);

        // Round-robin with all requesters valid, starting from a fresh pointer
        rst = 1'b1;
        step(g);
        rst = 1'b0;
        tv_valid = '1;
        for (int k = 0; k < N; k++) begin
            tv_addr[k] = 4'(k + 1);
            tv_data[k] = 32'(100 * (k + 1));
        end
        for (int c = 0; c < 6; c++) begin
            step(g);
            exp_wr = 16'h0002 << (c % 3);
            check("rr_gid", 32'(bus_a.grant_id), 32'(c % 3));
            check("rr_wr",  32'(bus_a.wr), 32'(exp_wr));
        end
        tv_valid = '0;
        step(g);

        // Same destination from requesters 1 and 2 with the pointer at 2
        tv_valid   = 3'b010;
        tv_addr[1] = 4'd4;
        step(g);
        tv_valid   = 3'b110;
        tv_addr[1] = 4'd7;
        tv_data[1] = 32'd11;
        tv_addr[2] = 4'd7;
        tv_data[2] = 32'd22;
        step(g);
        check("same_first_data", bus_a.data_in, 32'd22);
        check("same_first_wr",   32'(bus_a.wr), 32'h0000_0080);
        tv_valid[2] = 1'b0;
        step(g);
        check("same_second_data", bus_a.data_in, 32'd11);
        check("same_second_wr",   32'(bus_a.wr), 32'h0000_0080);
        tv_valid = '0;
        step(g);

        // Stall with everyone valid; grant resumes at the held pointer (2)
        tv_valid = '1;
        for (int k = 0; k < N; k++) tv_addr[k] = 4'(10 + k);
        tv_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(g);
            check("stall_wr", 32'(bus_a.wr), 32'd0);
        end
        tv_stall = 1'b0;
        step(g);
        check("stall_resume_gid", 32'(bus_a.grant_id), 32'd2);
        tv_valid = '0;
        step(g);

        // Protected r0 write: accepted, no strobe, pointer advances
        rst = 1'b1;
        step(g);
        rst        = 1'b0;
        tv_valid   = 3'b001;
        tv_addr[0] = 4'd0;
        tv_data[0] = 32'h0000_A5A5;
        step(g);
        check("r0_wr_b",  32'(bus_b.wr), 32'd0);
        check("r0_act_b", 32'(bus_b.wr_active), 32'd1);
        check("r0_wr_a",  32'(bus_a.wr), 32'd1);
        tv_valid   = 3'b011;
        tv_addr[1] = 4'd3;
        step(g);
        check("r0_ptr_gid_b", 32'(bus_b.grant_id), 32'd1);
        tv_valid = '0;
        step(g);

        // Reset arriving right after a transfer
        tv_valid   = 3'b100;
        tv_addr[2] = 4'd6;
        tv_data[2] = 32'h1234_5678;
        step(g);
        check("mid_wr", 32'(bus_a.wr), 32'h0000_0040);
        rst      = 1'b1;
        tv_valid = 3'b111;
        step(g);
        check("mid_rst_wr",   32'(bus_a.wr), 32'd0);
        check("mid_rst_data", bus_a.data_in, 32'd0);
        step(g);
        rst      = 1'b0;
        tv_valid = 3'b110;
        step(g);
        check("post_rst_gid", 32'(bus_a.grant_id), 32'd1);
        tv_valid = '0;
        step(g);

        // Random traffic; a requester holds its request until granted
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!tv_valid[k] && ($urandom_range(0, 2) != 0)) begin
                    tv_valid[k] = 1'b1;
                    tv_addr[k]  = 4'($urandom_range(0, 15));
                    tv_data[k]  = $urandom;
                end
            end
            tv_stall = ($urandom_range(0, 6) == 0);
            rst      = ($urandom_range(0, 60) == 0);
            step(g);
            if (g >= 0) tv_valid[g] = 1'b0;
        end
        rst      = 1'b0;
        tv_stall = 1'b0;
        tv_valid = '0;
        step(g);
        step(g);

        // Bank contents implied by the observed write pulses versus the model's writer order
        for (int b = 0; b < 16; b++) begin
            check("bank", t_bank[b], m_bank[b]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/regbank_wb_arbiter.md
# regbank_wb_arbiter

Write-port arbiter and sequencer for the 16x32 register bank. Up to four writeback requesters (ALU, load unit, multiplier, …) share the bank's single write port. The block grants one request per cycle by round-robin, decodes the 4-bit destination into the bank's one-hot 16-bit `wr` strobe, and drives `wr`/`data_in` from registers, so the bank sees a clean single-cycle write pulse.

## Interface
- `N_REQ`, 3: number of requesters; legal range 2..4.
- `PROTECT_R0`, 0: when 1, writes to address 0 are accepted but suppressed (no `wr` bit set).
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `req_valid`  in  N_REQ: per-requester write request.
- `req_addr`  in  4*N_REQ: destination register; requester i uses bits [4i+3:4i].
- `req_data`  in  32*N_REQ: write data; requester i uses bits [32i+31:32i].
- `req_ready`  out  N_REQ: grant; combinational, at most one bit high.
- `stall`  in  1: freezes arbitration; no grants while high.
- `wr`  out  16: one-hot write strobe to the bank; registered.
- `data_in`  out  32: write data to the bank; registered.
- `grant_id`  out  2: index of the requester that produced the current `wr` pulse; registered.
- `wr_active`  out  1: high in the cycle the bank write occurs; equals |`wr`, except it is also high for suppressed R0 writes.

## Operation
- Handshake: a transfer occurs on a rising edge where `req_valid[i] && req_ready[i]`. A requester holds `valid`, `addr` and `data` stable until it is granted.
- Arbitration: rotating priority pointer `ptr` (0..N_REQ-1).
  - The search starts at `ptr` and wraps modulo N_REQ. The first valid requester is granted.
  - After a transfer from requester g, `ptr` becomes (g+1) mod N_REQ.
  - With no transfer, `ptr` holds.
- Fairness: a continuously valid requester is granted within N_REQ cycles.
- `stall` = 1: `req_ready` is all-zero and `ptr` holds. The output stage still completes any pulse registered in the previous cycle.
- Decode: on a transfer, the next-cycle `wr` = 16'b1 << addr, `data_in` = data, `grant_id` = g, `wr_active` = 1.
- `PROTECT_R0` = 1 with addr = 0: the transfer is accepted (ready high, `ptr` advances, `wr_active` = 1), but `wr` = 0.
- Idle cycles (no transfer):
  - `wr` = 0 and `wr_active` = 0.
  - `data_in` and `grant_id` hold their last values. The bank ignores them when `wr` = 0.
- Same-address requests in one cycle: only the granted one is written. The others wait and are written in later cycles in grant order, so the last writer wins in bank state.
- Requester indices ≥ N_REQ do not exist. Unused `grant_id` codes never appear.

## Timing
- Latency: handshake in cycle T produces the `wr` pulse in cycle T+1, with width exactly one cycle.
- Throughput: one write per cycle sustained, with no bubbles between back-to-back grants.
- `req_ready` depends combinationally on `req_valid`, `stall` and `ptr` only, not on `addr` or `data`.
- Reset (`rst` high at an edge) forces: `wr` = 0, `data_in` = 0, `grant_id` = 0, `wr_active` = 0, `ptr` = 0.
  - While `rst` is high, `req_ready` = 0.
  - A request presented during reset is not accepted.
  - A pulse registered in the cycle before reset is cleared at the reset edge.
- First cycle after reset deasserts: requester 0 has priority.

## Test plan
- Single request: `req_valid` = 001, addr 5, data 32'hDEADBEEF at T → `req_ready[0]` = 1 at T; at T+1 `wr` = 16'h0020, `data_in` = DEADBEEF, `grant_id` = 0; at T+2 `wr` = 0.
- Round-robin, all three valid for 6 cycles (addrs 1/2/3) → grants 0,1,2,0,1,2. `wr` sequence: 0002,0004,0008,0002,0004,0008, one pulse per cycle.
- Same address, requesters 1 and 2 both target r7 (data 11, 22) with `ptr` = 2 → cycle A grants 2 (`data_in` 22), cycle B grants 1 (`data_in` 11). Both pulses have `wr` = 16'h0080.
- Stall: all valid, `stall` high for 3 cycles → `req_ready` = 000 and `wr` = 0 throughout. After release, the grant resumes at the held `ptr`.
- `PROTECT_R0` = 1: requester 0 writes addr 0 → `req_ready[0]` = 1; next cycle `wr` = 0, `wr_active` = 1, `ptr` = 1.
- Reset mid-stream: a transfer at T with `rst` high at T+1 → `wr` = 0 and `data_in` = 0 after T+1. `req_ready` stays 0 while in reset. The first post-reset grant goes to the lowest valid index.
